// File: rtl/debug_ocimem_if.sv
// ============================================================================
// debug_ocimem_if : debug command strobes, OCI memory master bus and monitor status
// Revision 1.0
// ============================================================================
`default_nettype none

interface debug_ocimem_if #(
  parameter int ADDR_W = 8
) ();
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic              take_no_action_ocimem_a;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_waitrequest;
  logic [31:0]       mem_readdata;
  logic              mem_readdatavalid;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;
  logic              busy;

  modport master (
    input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
    input  mem_waitrequest, mem_readdata, mem_readdatavalid,
    output mem_address, mem_read, mem_write, mem_writedata,
    output MonDReg, monitor_ready, monitor_error, busy
  );

  modport slave (
    output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
    output mem_waitrequest, mem_readdata, mem_readdatavalid,
    input  mem_address, mem_read, mem_write, mem_writedata,
    input  MonDReg, monitor_ready, monitor_error, busy
  );
endinterface

`default_nettype wire

// File: rtl/debug_ocimem_agent.sv
// ============================================================================
// debug_ocimem_agent : JTAG debug commands -> single-word OCI memory reads/writes
// Optional request timeout enabled by macro DEBUG_OCIMEM_TIMEOUT_EN.  Revision 1.0
// ============================================================================
`default_nettype none

module debug_ocimem_agent #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           reset,
  debug_ocimem_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    WR_REQ  = 2'd3
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       mondreg_q, mondreg_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rhold_q, rhold_d;
  logic              rpend_q, rpend_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic              read_q, write_q, busy_q;
  logic              any_strobe, multi_strobe, timeout_w;

  assign any_strobe   = bus.take_action_ocimem_a | bus.take_action_ocimem_b |
                        bus.take_no_action_ocimem_a;
  assign multi_strobe = (bus.take_action_ocimem_a & bus.take_action_ocimem_b) |
                        (bus.take_action_ocimem_a & bus.take_no_action_ocimem_a) |
                        (bus.take_action_ocimem_b & bus.take_no_action_ocimem_a);

`ifdef DEBUG_OCIMEM_TIMEOUT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else if (state_d != state_q) begin
      cnt_q <= 8'd0;
    end else if (state_q != IDLE) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign timeout_w = (state_q != IDLE) && (cnt_q == TIMEOUT_C - 8'd1);
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = TIMEOUT_C;
  assign timeout_w      = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    mondreg_d = mondreg_q;
    wdata_d   = wdata_q;
    rhold_d   = rhold_q;
    rpend_d   = rpend_q;
    ready_d   = ready_q;
    error_d   = error_q;

    // Overrun: strobes outside IDLE are dropped but flagged.
    if (state_q != IDLE && any_strobe) begin
      error_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.take_action_ocimem_a) begin
          addr_d  = bus.jdo[ADDR_W+16:17];
          ready_d = 1'b0;
          if (bus.jdo[35]) error_d = 1'b0;
          if (bus.jdo[34]) state_d = RD_REQ;
        end else if (bus.take_action_ocimem_b) begin
          wdata_d = bus.jdo[34:3];
          ready_d = 1'b0;
          state_d = WR_REQ;
        end else if (bus.take_no_action_ocimem_a) begin
          ready_d = 1'b0;
          state_d = RD_REQ;
        end
        if (multi_strobe) error_d = 1'b1;
      end
      RD_REQ: begin
        if (!bus.mem_waitrequest) begin
          // A response coinciding with acceptance is held and retired in RD_WAIT.
          state_d = RD_WAIT;
          rpend_d = bus.mem_readdatavalid;
          rhold_d = bus.mem_readdata;
        end else if (timeout_w) begin
          state_d = IDLE;
          error_d = 1'b1;
          ready_d = 1'b1;
        end
      end
      RD_WAIT: begin
        if (rpend_q || bus.mem_readdatavalid) begin
          mondreg_d = rpend_q ? rhold_q : bus.mem_readdata;
          ready_d   = 1'b1;
          addr_d    = addr_q + 1'b1;
          rpend_d   = 1'b0;
          state_d   = IDLE;
        end else if (timeout_w) begin
          state_d = IDLE;
          error_d = 1'b1;
          ready_d = 1'b1;
        end
      end
      WR_REQ: begin
        if (!bus.mem_waitrequest) begin
          ready_d = 1'b1;
          addr_d  = addr_q + 1'b1;
          state_d = IDLE;
        end else if (timeout_w) begin
          state_d = IDLE;
          error_d = 1'b1;
          ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      mondreg_q <= 32'd0;
      wdata_q   <= 32'd0;
      rhold_q   <= 32'd0;
      rpend_q   <= 1'b0;
      ready_q   <= 1'b1;
      error_q   <= 1'b0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      mondreg_q <= mondreg_d;
      wdata_q   <= wdata_d;
      rhold_q   <= rhold_d;
      rpend_q   <= rpend_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
      read_q    <= (state_d == RD_REQ);
      write_q   <= (state_d == WR_REQ);
      busy_q    <= (state_d != IDLE);
    end
  end

  assign bus.mem_address   = addr_q;
  assign bus.mem_read      = read_q;
  assign bus.mem_write     = write_q;
  assign bus.mem_writedata = wdata_q;
  assign bus.MonDReg       = mondreg_q;
  assign bus.monitor_ready = ready_q;
  assign bus.monitor_error = error_q;
  assign bus.busy          = busy_q;

endmodule

`default_nettype wire
